// File: rtl/lcd_ctrl_if.sv
// Client write-request handshake for the LCD sequencer.
interface lcd_ctrl_if;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;

  modport master (output req_valid, output req_rs, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rs, input req_data, output req_ready);
endinterface

// File: rtl/lcd_ctrl.sv
// 8-bit character LCD sequencer: init hand-off, fixed config list, then client writes.
module lcd_ctrl #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_E     = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLEAR = 82000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        init_start,
  input  logic        init_done,
  input  logic [7:0]  init_db,
  input  logic        init_e,
  lcd_ctrl_if.slave   req,
  output logic        ready,
  output logic [7:0]  lcd_db,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e
);

  localparam int unsigned TW = ($clog2(T_CLEAR) > 17) ? $clog2(T_CLEAR) : 17;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_START, S_INIT_WAIT,
    S_CFG_SETUP, S_CFG_E, S_CFG_HOLD, S_CFG_WAIT,
    S_READY,
    S_WR_SETUP, S_WR_E, S_WR_HOLD, S_WR_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [1:0]      r_idx;
  logic [7:0]      r_byte;
  logic            r_rs;
  logic            w_setup_end;
  logic            w_e_end;
  logic            w_hold_end;
  logic            w_wait_end;
  logic            w_is_clear;

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_byte = 8'h38;
      2'd1:    cfg_byte = 8'h06;
      2'd2:    cfg_byte = 8'h0C;
      default: cfg_byte = 8'h01;
    endcase
  endfunction

  // Clear and home commands need the long busy wait.
  assign w_is_clear  = !r_rs && (r_byte == 8'h01 || r_byte == 8'h02 || r_byte == 8'h03);
  assign w_setup_end = (r_timer == TW'(T_SETUP - 1));
  assign w_e_end     = (r_timer == TW'(T_E - 1));
  assign w_hold_end  = (r_timer == TW'(T_HOLD - 1));
  assign w_wait_end  = (r_timer == (w_is_clear ? TW'(T_CLEAR - 1) : TW'(T_CMD - 1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    init_start    = 1'b0;
    req.req_ready = 1'b0;
    ready         = 1'b0;
    lcd_db        = 8'h00;
    lcd_rs        = 1'b0;
    lcd_rw        = 1'b0;
    lcd_e         = 1'b0;

    if (r_state inside {S_CFG_SETUP, S_CFG_E, S_CFG_HOLD, S_CFG_WAIT,
                        S_WR_SETUP, S_WR_E, S_WR_HOLD, S_WR_WAIT}) begin
      lcd_db = r_byte;
      lcd_rs = r_rs;
    end

    case (r_state)
      S_IDLE:       if (start) w_state_nxt = S_INIT_START;
      S_INIT_START: begin
        init_start  = 1'b1;
        lcd_db      = init_db;
        lcd_e       = init_e;
        w_state_nxt = S_INIT_WAIT;
      end
      S_INIT_WAIT:  begin
        lcd_db = init_db;
        lcd_e  = init_e;
        if (init_done) w_state_nxt = S_CFG_SETUP;
      end
      S_CFG_SETUP:  if (w_setup_end) w_state_nxt = S_CFG_E;
      S_CFG_E:      begin
        lcd_e = 1'b1;
        if (w_e_end) w_state_nxt = S_CFG_HOLD;
      end
      S_CFG_HOLD:   if (w_hold_end) w_state_nxt = S_CFG_WAIT;
      S_CFG_WAIT:   if (w_wait_end) w_state_nxt = (r_idx == 2'd3) ? S_READY : S_CFG_SETUP;
      S_READY:      begin
        ready         = 1'b1;
        req.req_ready = 1'b1;
        if (req.req_valid) w_state_nxt = S_WR_SETUP;
      end
      S_WR_SETUP:   if (w_setup_end) w_state_nxt = S_WR_E;
      S_WR_E:       begin
        lcd_e = 1'b1;
        if (w_e_end) w_state_nxt = S_WR_HOLD;
      end
      S_WR_HOLD:    if (w_hold_end) w_state_nxt = S_WR_WAIT;
      S_WR_WAIT:    if (w_wait_end) w_state_nxt = S_READY;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // Phase timer restarts on every state change; byte/rs latch on config entry or accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
      r_idx   <= 2'd0;
      r_byte  <= 8'h00;
      r_rs    <= 1'b0;
    end else begin
      r_timer <= (w_state_nxt != r_state) ? '0 : r_timer + TW'(1);
      if (r_state == S_INIT_WAIT && init_done) begin
        r_idx  <= 2'd0;
        r_byte <= cfg_byte(2'd0);
        r_rs   <= 1'b0;
      end else if (r_state == S_CFG_WAIT && w_wait_end && r_idx != 2'd3) begin
        r_idx  <= r_idx + 2'd1;
        r_byte <= cfg_byte(r_idx + 2'd1);
      end else if (r_state == S_READY && req.req_valid) begin
        r_byte <= req.req_data;
        r_rs   <= req.req_rs;
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened busy waits.
module tb_lcd_ctrl;
  localparam int T_SETUP = 2;
  localparam int T_E     = 12;
  localparam int T_HOLD  = 2;
  localparam int T_CMD   = 20;
  localparam int T_CLEAR = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       init_start;
  logic       init_done;
  logic [7:0] init_db;
  logic       init_e;
  logic       ready;
  logic [7:0] lcd_db;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;

  int n_cmp = 0;
  int n_err = 0;

  lcd_ctrl_if bus();

  lcd_ctrl #(.T_SETUP(T_SETUP), .T_E(T_E), .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)) dut (
    .clk(clk), .reset(reset), .start(start), .init_start(init_start),
    .init_done(init_done), .init_db(init_db), .init_e(init_e), .req(bus),
    .ready(ready), .lcd_db(lcd_db), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic count_level(input logic lvl, output int n);
    n = 0;
    while (lcd_e === lvl && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; init_done = 1'b0; init_e = 1'b0; init_db = 8'h00;
    bus.req_valid = 1'b0; bus.req_rs = 1'b0; bus.req_data = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ready, bus.req_ready, lcd_e, lcd_rs, lcd_rw, init_start, lcd_db} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_outputs got %h exp 0", {ready, bus.req_ready, lcd_e, lcd_rs, lcd_rw, init_start, lcd_db});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ready, init_start, lcd_e} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset got %b exp 000", {ready, init_start, lcd_e});
    end
  endtask

  task automatic test_init();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    init_done = 1'b1; init_e = 1'b1; init_db = 8'hA5;
    #1;
    n_cmp++;
    if (init_start !== 1'b1) begin n_err++; $display("FAIL init_start_pulse got %b exp 1", init_start); end
    n_cmp++;
    if ({lcd_e, lcd_db, lcd_rs} !== {1'b1, 8'hA5, 1'b0}) begin
      n_err++; $display("FAIL init_mux_hi got e=%b db=%h rs=%b exp e=1 db=a5 rs=0", lcd_e, lcd_db, lcd_rs);
    end
    @(negedge clk);
    init_done = 1'b0;
    n_cmp++;
    if (init_start !== 1'b0) begin n_err++; $display("FAIL init_start_width got %b exp 0", init_start); end
    init_e = 1'b0; init_db = 8'h3C;
    #1;
    n_cmp++;
    if ({lcd_e, lcd_db} !== {1'b0, 8'h3C}) begin
      n_err++; $display("FAIL init_mux_lo got e=%b db=%h exp e=0 db=3c", lcd_e, lcd_db);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ready, lcd_db} !== {1'b0, 8'h3C}) begin
      n_err++; $display("FAIL init_wait_hold got ready=%b db=%h exp ready=0 db=3c", ready, lcd_db);
    end
    init_done = 1'b1;
    @(negedge clk);
    init_done = 1'b0; init_db = 8'h00;
    n_cmp++;
    if ({lcd_db, lcd_rs, lcd_e} !== {8'h38, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL cfg_first_byte got db=%h rs=%b e=%b exp db=38 rs=0 e=0", lcd_db, lcd_rs, lcd_e);
    end
  endtask

  task automatic test_config();
    logic [7:0] exp_b [4];
    int n;
    exp_b[0] = 8'h38; exp_b[1] = 8'h06; exp_b[2] = 8'h0C; exp_b[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      count_level(1'b0, n);
      n_cmp++;
      if (n != ((i == 0) ? T_SETUP : T_HOLD + T_CMD + T_SETUP)) begin
        n_err++; $display("FAIL cfg_gap[%0d] got %0d exp %0d", i, n, (i == 0) ? T_SETUP : T_HOLD + T_CMD + T_SETUP);
      end
      n_cmp++;
      if ({lcd_db, lcd_rs} !== {exp_b[i], 1'b0}) begin
        n_err++; $display("FAIL cfg_byte[%0d] got db=%h rs=%b exp db=%h rs=0", i, lcd_db, lcd_rs, exp_b[i]);
      end
      count_level(1'b1, n);
      n_cmp++;
      if (n != T_E) begin n_err++; $display("FAIL cfg_e_width[%0d] got %0d exp %0d", i, n, T_E); end
    end
    n = 0;
    while (ready !== 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n != T_HOLD + T_CLEAR) begin n_err++; $display("FAIL cfg_clear_wait got %0d exp %0d", n, T_HOLD + T_CLEAR); end
  endtask

  task automatic test_write(input logic rs, input logic [7:0] data, input int exp_wait, input bit keep);
    int first;
    int last;
    int k;
    bit db_bad;
    n_cmp++;
    if ({bus.req_ready, ready} !== 2'b11) begin
      n_err++; $display("FAIL wr_%h_ready_before got %b exp 11", data, {bus.req_ready, ready});
    end
    bus.req_valid = 1'b1; bus.req_rs = rs; bus.req_data = data;
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, ready, lcd_rs, lcd_db} !== {1'b0, 1'b0, rs, data}) begin
      n_err++; $display("FAIL wr_%h_capture got rdy=%b rs=%b db=%h exp rdy=0 rs=%b db=%h",
                        data, bus.req_ready, lcd_rs, lcd_db, rs, data);
    end
    bus.req_data = ~data; bus.req_rs = ~rs;
    first = 0; last = 0; k = 1; db_bad = 1'b0;
    while (bus.req_ready !== 1'b1 && k < 5000) begin
      if (lcd_e === 1'b1) begin
        if (first == 0) first = k;
        last = k;
      end
      if (lcd_db !== data || lcd_rs !== rs) db_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (first != T_SETUP + 1 || last != T_SETUP + T_E) begin
      n_err++; $display("FAIL wr_%h_e_window got %0d..%0d exp %0d..%0d", data, first, last, T_SETUP + 1, T_SETUP + T_E);
    end
    n_cmp++;
    if (k != T_SETUP + T_E + T_HOLD + exp_wait + 1) begin
      n_err++; $display("FAIL wr_%h_ready_return got %0d exp %0d", data, k - 1, T_SETUP + T_E + T_HOLD + exp_wait);
    end
    n_cmp++;
    if (db_bad) begin n_err++; $display("FAIL wr_%h_bus_stable got unstable exp stable", data); end
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic test_ignore();
    start = 1'b1; init_done = 1'b1;
    @(negedge clk);
    start = 1'b0; init_done = 1'b0;
    n_cmp++;
    if ({ready, bus.req_ready, init_start, lcd_e, lcd_db} !== {4'b1100, 8'h00}) begin
      n_err++; $display("FAIL ready_ignores_pulses got %b exp 110000000000",
                        {ready, bus.req_ready, init_start, lcd_e, lcd_db});
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ready, init_start} !== 2'b10) begin
      n_err++; $display("FAIL ready_stays got %b exp 10", {ready, init_start});
    end
  endtask

  task automatic test_back_to_back();
    test_write(1'b1, 8'h42, T_CMD, 1'b1);
    test_write(1'b0, 8'h80, T_CMD, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1; bus.req_rs = 1'b1; bus.req_data = 8'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (lcd_e !== 1'b1) begin n_err++; $display("FAIL mid_in_e_phase got %b exp 1", lcd_e); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({lcd_e, lcd_db, bus.req_ready, ready} !== 11'h0) begin
      n_err++; $display("FAIL mid_reset_async got %h exp 0", {lcd_e, lcd_db, bus.req_ready, ready});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({ready, init_start, lcd_e, lcd_db} !== 11'h0) begin
      n_err++; $display("FAIL mid_stays_idle got %h exp 0", {ready, init_start, lcd_e, lcd_db});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (init_start !== 1'b1) begin n_err++; $display("FAIL mid_restart got %b exp 1", init_start); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_config();
    test_write(1'b1, 8'h41, T_CMD, 1'b0);
    test_write(1'b0, 8'h01, T_CLEAR, 1'b0);
    test_write(1'b0, 8'h80, T_CMD, 1'b0);
    test_write(1'b0, 8'h03, T_CLEAR, 1'b0);
    test_write(1'b0, 8'h04, T_CMD, 1'b0);
    test_write(1'b1, 8'h01, T_CMD, 1'b0);
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
Top-level sequencer for the 8-bit character LCD bus. After `start`, it runs the power-on init block and waits for its `done`. It then issues the fixed configuration command list and afterwards serves single command/data writes from a client through a valid/ready handshake. It owns the LCD pins and muxes them between the init block and its own write engine.

Parameters:
T_SETUP, 2, cycles RS/DB are stable before E rises
T_E, 12, cycles E is held high
T_HOLD, 2, cycles RS/DB are held after E falls
T_CMD, 2000, busy wait after a normal command or data write (40 us at 50 MHz)
T_CLEAR, 82000, busy wait after clear/home (1.64 ms at 50 MHz)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
start  in  1  one-cycle pulse; begins full bring-up; honoured only in IDLE
init_start  out  1  one-cycle pulse to the init block's init input
init_done  in  1  one-cycle done pulse from the init block
init_db  in  8  init block data bus
init_e  in  1  init block enable strobe
req_valid  in  1  client write request
req_rs  in  1  0 = command, 1 = character data
req_data  in  8  byte to write
req_ready  out  1  high only in READY; the transfer happens on the cycle where req_valid and req_ready are both high
ready  out  1  high while in READY (configuration complete, engine idle)
lcd_db  out  8  LCD data bus
lcd_rs  out  1  LCD register select
lcd_rw  out  1  tied 0; write-only
lcd_e  out  1  LCD enable

Behaviour:
- Reset: async to IDLE. All outputs are 0. The config index and the timer are cleared.
- States and transitions:
  - IDLE: on `start`, go to INIT_START.
  - INIT_START: lasts 1 cycle and asserts `init_start`, then goes to INIT_WAIT.
  - INIT_WAIT: on `init_done`, go to CFG_SETUP with config index 0.
  - CFG_SETUP, CFG_E, CFG_HOLD, CFG_WAIT: write the config entry.
  - After CFG_WAIT: if the index is below 3, increment it and go to CFG_SETUP; otherwise go to READY.
  - READY: on accepted request, go to WR_SETUP.
  - WR_SETUP, WR_E, WR_HOLD, WR_WAIT: write the request, then return to READY.
- Config list, all with rs = 0, in this order:
  - 0x38 (8-bit, 2 lines, 5x8)
  - 0x06 (entry mode increment)
  - 0x0C (display on, cursor off)
  - 0x01 (clear)
- Phase lengths in each write:
  - SETUP lasts exactly T_SETUP cycles with lcd_e = 0.
  - E lasts exactly T_E cycles with lcd_e = 1.
  - HOLD lasts exactly T_HOLD cycles with lcd_e = 0.
  - WAIT lasts T_CLEAR cycles if rs = 0 and byte is 0x01, 0x02 or 0x03; otherwise T_CMD cycles.
- Timer: a single up-counter, at least 17 bits, cleared on every state entry. A phase ends when the counter reaches its length minus 1.
- Bus mux:
  - In INIT_START and INIT_WAIT: lcd_db = init_db, lcd_e = init_e, lcd_rs = 0.
  - In the CFG and WR states: lcd_db and lcd_rs come from an internal byte/rs register. The register is loaded on config entry or on handshake acceptance and is constant through SETUP, E, HOLD and WAIT.
  - In IDLE and READY: lcd_db = 0, lcd_rs = 0, lcd_e = 0.
- Handshake:
  - req_data and req_rs are captured on the accept edge. The first WR_SETUP cycle immediately follows.
  - req_ready is 0 from that cycle until back in READY.
  - Accept-to-next-ready: T_SETUP + T_E + T_HOLD + wait cycles.
  - req_valid outside READY is ignored (no queueing). The client holds the request until it is accepted.
- Edge cases:
  - `start` outside IDLE is ignored.
  - `init_done` outside INIT_WAIT is ignored.
  - `init_done` coincident with the INIT_START cycle is ignored; INIT_WAIT waits for the next pulse.
- Reset mid-write: lcd_e drops immediately (async). Re-bring-up requires a new `start`.

Test Plan:
- reset, then `start` pulse → init_start = 1 for exactly 1 cycle. While init_e toggles, lcd_e follows it with lcd_db = init_db. After an init_done pulse, lcd_db = 0x38 appears with lcd_rs = 0.
- Config sequence → four E pulses of exactly 12 cycles with bytes 0x38, 0x06, 0x0C, 0x01. The pulse gaps (E fall to next E rise) are 2+2000+2 cycles for the first three; ready rises 2+82000 cycles after the 0x01 E falls.
- In READY, req_valid = 1, rs = 1, data = 0x41 → accepted on the same edge; lcd_rs = 1 and lcd_db = 0x41 from the next cycle; lcd_e is high on cycles 3–14 after accept; req_ready returns 2016 cycles after accept.
- Command 0x01 with rs = 0 → same strobe timing; req_ready returns 82016 cycles after accept. Command 0x80 → 2016 cycles.
- req_valid held high during a write, and `start` and `init_done` pulsed in READY → exactly one write per READY visit; state and outputs are otherwise unchanged.
- reset asserted during the E phase of a write → lcd_e, lcd_db, req_ready and ready are 0 within the same cycle. The block stays in IDLE until `start`.
